mips_cpu: RTL and testbench

- Multicycle 32-bit MIPS subset processor with internal instruction memory, data memory, register file and a minimal CP0.
- Sits at the top of the CPU subsystem and reaches external devices through a bridge bus (PrAddr/PrDOut/PrDIn/Wen).
- Takes external hardware interrupts on HWInt.
- One instruction completes per 3–5 clock cycles, sequenced by a fetch/decode/execute/memory/writeback state machine.

---
 rtl/mips_cpu.sv | 248 ++++++++++++++++++++++++
 tb/tb_mips_cpu.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// Multicycle 32-bit MIPS subset CPU with internal IM/DM, GPRs, minimal CP0 and a device bridge bus.
// Latency: 3 to 5 clocks per instruction (fetch/decode/execute/memory/writeback).
// No backpressure: the device bus is assumed to respond in the same cycle (PrDIn sampled in MEM).
module mips_cpu #(
  parameter int          CP0_DEV_CNT = 6,
  parameter logic [31:0] CODE_SEG_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY   = 32'h0000_4180,
  parameter logic [31:0] DEV_BASE    = 32'h0000_7F00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            PrDIn,
  input  logic [CP0_DEV_CNT-1:0] HWInt,
  output logic                   Wen,
  output logic [31:0]            PrAddr,
  output logic [31:0]            PrDOut
);

  localparam logic [31:0] PRID = 32'h1234_5678;

  typedef enum logic [2:0] {
    S1 = 3'd1,  // fetch
    S2 = 3'd2,  // decode / register read
    S3 = 3'd3,  // execute / branch resolve
    S4 = 3'd4,  // memory
    S5 = 3'd5   // writeback
  } state_t;

  state_t state, state_nxt;

  logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
  logic [31:0] gpr [0:31];
  logic [31:0] im  [0:1023];
  logic [31:0] dm  [0:1023];

  logic [CP0_DEV_CNT-1:0] sr_im, cause_ip;
  logic                   sr_exl, sr_ie;
  logic [31:0]            epc, sr, cause, cp0_rdata;

  // instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext, br_target, j_target, alu_res, wb_dat;
  logic [4:0]  wb_dst;
  logic [9:0]  im_idx;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign imm      = ir[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  logic is_rtype, is_addu, is_subu, is_and, is_or, is_slt, is_sll, is_jr, is_alu_r;
  logic is_ori, is_lui, is_addiu, is_lw, is_sw, is_beq, is_bne, is_bltzal, is_j, is_jal;
  logic is_cop0, is_mfc0, is_mtc0, is_eret, goes_wb, is_dev, irq_pend, take_irq;

  assign is_rtype  = (opcode == 6'h00);
  assign is_addu   = is_rtype & (funct == 6'h21);
  assign is_subu   = is_rtype & (funct == 6'h23);
  assign is_and    = is_rtype & (funct == 6'h24);
  assign is_or     = is_rtype & (funct == 6'h25);
  assign is_slt    = is_rtype & (funct == 6'h2A);
  assign is_sll    = is_rtype & (funct == 6'h00);
  assign is_jr     = is_rtype & (funct == 6'h08);
  assign is_alu_r  = is_addu | is_subu | is_and | is_or | is_slt | is_sll;
  assign is_ori    = (opcode == 6'h0D);
  assign is_lui    = (opcode == 6'h0F);
  assign is_addiu  = (opcode == 6'h09);
  assign is_lw     = (opcode == 6'h23);
  assign is_sw     = (opcode == 6'h2B);
  assign is_beq    = (opcode == 6'h04);
  assign is_bne    = (opcode == 6'h05);
  assign is_bltzal = (opcode == 6'h01) & (rt == 5'h10);
  assign is_j      = (opcode == 6'h02);
  assign is_jal    = (opcode == 6'h03);
  assign is_cop0   = (opcode == 6'h10);
  assign is_mfc0   = is_cop0 & (rs == 5'h00);
  assign is_mtc0   = is_cop0 & (rs == 5'h04);
  assign is_eret   = is_cop0 & (rs == 5'h10) & (funct == 6'h18);
  assign goes_wb   = is_alu_r | is_ori | is_lui | is_addiu | is_mfc0 | is_mtc0;

  // PC already holds PC+4 once the fetch is done, so branch/jump targets build on it directly
  assign br_target = pc + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc[31:28], ir[25:0], 2'b00};

  // IM index wraps at 1024 words, so EXC_ENTRY aliases into the code segment
  assign im_idx = pc[11:2] - CODE_SEG_PC[11:2];

  assign is_dev   = (alu_out >= DEV_BASE);
  assign irq_pend = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign take_irq = (state == S1) & irq_pend;

  assign Wen    = (state == S4) & is_sw & is_dev;
  assign PrAddr = alu_out;
  assign PrDOut = b_reg;

  // assemble CP0 register views and the mfc0 read mux
  always_comb begin
    sr = '0;
    sr[10 +: CP0_DEV_CNT] = sr_im;
    sr[1] = sr_exl;
    sr[0] = sr_ie;
    cause = '0;
    cause[10 +: CP0_DEV_CNT] = cause_ip;
    case (rd)
      5'd12:   cp0_rdata = sr;
      5'd13:   cp0_rdata = cause;
      5'd14:   cp0_rdata = epc;
      5'd15:   cp0_rdata = PRID;
      default: cp0_rdata = '0;
    endcase
  end

  // ALU: operates on the operands latched in decode
  always_comb begin
    alu_res = '0;
    if (is_addu)                        alu_res = a_reg + b_reg;
    else if (is_subu)                   alu_res = a_reg - b_reg;
    else if (is_and)                    alu_res = a_reg & b_reg;
    else if (is_or)                     alu_res = a_reg | b_reg;
    else if (is_slt)                    alu_res = {31'd0, $signed(a_reg) < $signed(b_reg)};
    else if (is_sll)                    alu_res = b_reg << shamt;
    else if (is_ori)                    alu_res = a_reg | imm_zext;
    else if (is_lui)                    alu_res = {imm, 16'h0000};
    else if (is_addiu | is_lw | is_sw)  alu_res = a_reg + imm_sext;
  end

  // writeback destination and data selection
  always_comb begin
    wb_dst = is_rtype ? rd : rt;
    if (is_lw)        wb_dat = mdr;
    else if (is_mfc0) wb_dat = cp0_rdata;
    else              wb_dat = alu_out;
  end

  // next-state sequencing per instruction class
  always_comb begin
    state_nxt = state;
    case (state)
      S1: state_nxt = take_irq ? S1 : S2;
      S2: state_nxt = S3;
      S3: begin
        if (goes_wb)             state_nxt = S5;
        else if (is_lw | is_sw)  state_nxt = S4;
        else                     state_nxt = S1;
      end
      S4: state_nxt = is_lw ? S5 : S1;
      S5: state_nxt = S1;
      default: state_nxt = S1;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S1;
    else      state <= state_nxt;
  end

  // PC and IR: fetch, interrupt redirect, branch/jump/eret resolve
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= CODE_SEG_PC;
      ir <= '0;
    end else if (state == S1) begin
      if (take_irq) begin
        pc <= EXC_ENTRY;
      end else begin
        ir <= im[im_idx];
        pc <= pc + 32'd4;
      end
    end else if (state == S3) begin
      if ((is_beq & (a_reg == b_reg)) | (is_bne & (a_reg != b_reg)) | (is_bltzal & a_reg[31]))
        pc <= br_target;
      else if (is_j | is_jal)
        pc <= j_target;
      else if (is_jr)
        pc <= a_reg;
      else if (is_eret)
        pc <= epc;
    end
  end

  // datapath pipeline registers: operands, ALU result, memory data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      if (state == S2) begin
        a_reg <= gpr[rs];
        b_reg <= gpr[rt];
      end
      if (state == S3) alu_out <= alu_res;
      if (state == S4) mdr <= is_dev ? PrDIn : dm[alu_out[11:2]];
    end
  end

  // register file: link writes at the end of S3, normal writes at the end of S5
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if ((state == S3) & (is_bltzal | is_jal)) begin
      gpr[31] <= pc;
    end else if ((state == S5) & ~is_mtc0 & (wb_dst != 5'd0)) begin
      gpr[wb_dst] <= wb_dat;
    end
  end

  // data memory: contents survive reset; store happens at the end of S4
  always_ff @(posedge clk) begin
    if ((state == S4) & is_sw & ~is_dev) dm[alu_out[11:2]] <= b_reg;
  end

  // CP0: interrupt entry, eret, mtc0 writes, Cause.IP tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_im    <= '0;
      sr_exl   <= 1'b0;
      sr_ie    <= 1'b0;
      epc      <= '0;
      cause_ip <= '0;
    end else begin
      cause_ip <= HWInt;
      if (take_irq) begin
        epc    <= pc;
        sr_exl <= 1'b1;
      end else if ((state == S3) & is_eret) begin
        sr_exl <= 1'b0;
      end else if ((state == S5) & is_mtc0) begin
        if (rd == 5'd12) begin
          sr_im  <= b_reg[10 +: CP0_DEV_CNT];
          sr_exl <= b_reg[1];
          sr_ie  <= b_reg[0];
        end else if (rd == 5'd14) begin
          epc <= b_reg;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: directed table, corner-case sequences, random programs vs ISA model.
// Latency: checks each instruction's cycle count and architectural state at the instruction boundary.
// No backpressure: device reads are served combinationally from PrDIn.
module tb_mips_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PrDIn = '0;
  logic [5:0]  HWInt = '0;
  logic        Wen;
  logic [31:0] PrAddr, PrDOut;

  int checks = 0;
  int errors = 0;

  mips_cpu dut (
    .clk(clk), .rst(rst), .PrDIn(PrDIn), .HWInt(HWInt),
    .Wen(Wen), .PrAddr(PrAddr), .PrDOut(PrDOut)
  );

  always #5 clk = ~clk;

  // ISA-level reference state
  logic [31:0] prog  [0:1023];
  logic [31:0] mregs [0:31];
  logic [31:0] mdm   [0:1023];
  logic [31:0] m_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", nm, act, exp_v);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs_, input int rt_, input int rd_, input int sh);
    return {6'h00, 5'(rs_), 5'(rt_), 5'(rd_), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs_, input int rt_, input logic [15:0] im16);
    return {op, 5'(rs_), 5'(rt_), im16};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction

  function automatic logic [31:0] enc_cop0(input int sub, input int rt_, input int rd_);
    return {6'h10, 5'(sub), 5'(rt_), 5'(rd_), 11'd0};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    logic [31:0] off;
    off = addr - 32'h0000_3000;
    dut.im[off[11:2]] = w;
    prog[off[11:2]] = w;
  endtask

  task automatic clear_im;
    for (int i = 0; i < 1024; i++) put(32'h3000 + 32'(i * 4), 32'h0);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // run one instruction from an S1 boundary to the next, bounded
  task automatic exec_one(output int cyc, output int wen_cnt, output logic [31:0] wa, output logic [31:0] wd);
    cyc = 0; wen_cnt = 0; wa = '0; wd = '0;
    do begin
      if (Wen) begin wen_cnt++; wa = PrAddr; wd = PrDOut; end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (dut.state != 3'd1 && cyc < 20);
  endtask

  task automatic m_wr(input int r, input logic [31:0] v);
    if (r != 0) mregs[r] = v;
  endtask

  // reference interpreter: one instruction, returns expected cycle count
  task automatic m_step(output int cyc);
    logic [31:0] off, ins, rsv, rtv, se, np, addr;
    logic [5:0]  op, fn;
    int rs_, rt_, rd_;
    off = m_pc - 32'h3000;
    ins = prog[off[11:2]];
    op = ins[31:26]; fn = ins[5:0];
    rs_ = int'(ins[25:21]); rt_ = int'(ins[20:16]); rd_ = int'(ins[15:11]);
    rsv = mregs[rs_]; rtv = mregs[rt_];
    se = {{16{ins[15]}}, ins[15:0]};
    np = m_pc + 32'd4;
    addr = rsv + se;
    cyc = 3;
    case (op)
      6'h00: begin
        cyc = 4;
        case (fn)
          6'h21: m_wr(rd_, rsv + rtv);
          6'h23: m_wr(rd_, rsv - rtv);
          6'h24: m_wr(rd_, rsv & rtv);
          6'h25: m_wr(rd_, rsv | rtv);
          6'h2A: m_wr(rd_, ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0);
          6'h00: m_wr(rd_, rtv << ins[10:6]);
          6'h08: begin np = rsv; cyc = 3; end
          default: cyc = 3;
        endcase
      end
      6'h0D: begin m_wr(rt_, rsv | {16'h0, ins[15:0]}); cyc = 4; end
      6'h0F: begin m_wr(rt_, {ins[15:0], 16'h0}); cyc = 4; end
      6'h09: begin m_wr(rt_, rsv + se); cyc = 4; end
      6'h23: begin m_wr(rt_, mdm[addr[11:2]]); cyc = 5; end
      6'h2B: begin mdm[addr[11:2]] = rtv; cyc = 4; end
      6'h04: if (rsv == rtv) np = np + (se << 2);
      6'h05: if (rsv != rtv) np = np + (se << 2);
      6'h01: if (rt_ == 16) begin
        m_wr(31, np);
        if (rsv[31]) np = np + (se << 2);
      end
      6'h02: np = {np[31:28], ins[25:0], 2'b00};
      6'h03: begin m_wr(31, np); np = {np[31:28], ins[25:0], 2'b00}; end
      default: cyc = 3;
    endcase
    m_pc = np;
  endtask

  function automatic logic [31:0] rnd_instr();
    int k, a, b, c;
    logic [15:0] off16;
    k = int'($urandom_range(0, 16));
    a = int'($urandom_range(0, 7));
    b = int'($urandom_range(0, 7));
    c = int'($urandom_range(0, 7));
    off16 = 16'($urandom_range(0, 12)) - 16'd6;
    case (k)
      0:  return enc_r(6'h21, a, b, c, 0);
      1:  return enc_r(6'h23, a, b, c, 0);
      2:  return enc_r(6'h24, a, b, c, 0);
      3:  return enc_r(6'h25, a, b, c, 0);
      4:  return enc_r(6'h2A, a, b, c, 0);
      5:  return enc_r(6'h00, 0, b, c, int'($urandom_range(0, 31)));
      6:  return enc_i(6'h0D, a, b, 16'($urandom));
      7:  return enc_i(6'h0F, 0, b, 16'($urandom));
      8:  return enc_i(6'h09, a, b, 16'($urandom));
      9:  return enc_i(6'h23, 0, b, 16'(4 * $urandom_range(0, 7)));
      10: return enc_i(6'h2B, 0, b, 16'(4 * $urandom_range(0, 7)));
      11: return enc_i(6'h04, a, b, off16);
      12: return enc_i(6'h05, a, b, off16);
      13: return enc_i(6'h01, a, 16, off16);
      14: return {6'h02, 26'(32'hC00 + $urandom_range(0, 1023))};
      15: return {6'h03, 26'(32'hC00 + $urandom_range(0, 1023))};
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ins;
    int          r;
    logic [31:0] rv;
    int          cyc;
    logic [31:0] npc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int cyc, wcnt, mcyc, bad, j;
    logic [31:0] wa, wd;

    // ---------------- reset state ----------------
    do_reset;
    chk("rst_pc", dut.pc, 32'h3000);
    chk("rst_state", 32'(dut.state), 32'd1);
    chk("rst_ir", dut.ir, 32'h0);
    chk("rst_wen", 32'(Wen), 32'd0);
    chk("rst_praddr", PrAddr, 32'h0);
    chk("rst_prdout", PrDOut, 32'h0);
    chk("rst_gpr31", dut.gpr[31], 32'h0);
    chk("rst_sr", dut.sr, 32'h0);
    chk("rst_epc", dut.epc, 32'h0);

    // ---------------- directed table ----------------
    tbl.push_back('{32'h3000, enc_i(6'h0F, 0, 2, 16'hFFFF),  2, 32'hFFFF_0000, 4, 32'h3004});
    tbl.push_back('{32'h3004, enc_i(6'h0D, 2, 2, 16'hFFFF),  2, 32'hFFFF_FFFF, 4, 32'h3008});
    tbl.push_back('{32'h3008, enc_i(6'h01, 2, 16, 16'd3),   31, 32'h0000_300C, 3, 32'h3018});
    tbl.push_back('{32'h3018, enc_i(6'h0D, 0, 1, 16'h1234),  1, 32'h0000_1234, 4, 32'h301C});
    tbl.push_back('{32'h301C, enc_i(6'h2B, 0, 1, 16'h0000),  0, 32'h0000_0000, 4, 32'h3020});
    tbl.push_back('{32'h3020, enc_i(6'h23, 0, 3, 16'h0000),  3, 32'h0000_1234, 5, 32'h3024});
    tbl.push_back('{32'h3024, enc_r(6'h21, 1, 2, 5, 0),      5, 32'h0000_1233, 4, 32'h3028});
    tbl.push_back('{32'h3028, enc_r(6'h23, 0, 1, 6, 0),      6, 32'hFFFF_EDCC, 4, 32'h302C});
    tbl.push_back('{32'h302C, enc_r(6'h2A, 2, 1, 7, 0),      7, 32'h0000_0001, 4, 32'h3030});
    tbl.push_back('{32'h3030, enc_r(6'h00, 0, 1, 8, 4),      8, 32'h0001_2340, 4, 32'h3034});
    tbl.push_back('{32'h3034, enc_r(6'h24, 2, 1, 9, 0),      9, 32'h0000_1234, 4, 32'h3038});
    tbl.push_back('{32'h3038, enc_i(6'h09, 1, 10, 16'hFFCC),10, 32'h0000_1200, 4, 32'h303C});
    tbl.push_back('{32'h303C, enc_i(6'h0D, 0, 0, 16'h0005),  0, 32'h0000_0000, 4, 32'h3040});
    tbl.push_back('{32'h3040, enc_i(6'h0D, 0, 11, 16'h8001),11, 32'h0000_8001, 4, 32'h3044});
    tbl.push_back('{32'h3044, enc_i(6'h04, 1, 3, 16'd2),     0, 32'h0000_0000, 3, 32'h3050});
    tbl.push_back('{32'h3050, enc_i(6'h05, 1, 3, 16'd5),     0, 32'h0000_0000, 3, 32'h3054});
    tbl.push_back('{32'h3054, enc_i(6'h09, 0, 12, 16'd1),   12, 32'h0000_0001, 4, 32'h3058});
    tbl.push_back('{32'h3058, enc_i(6'h01, 12, 16, 16'd3),  31, 32'h0000_305C, 3, 32'h305C});
    tbl.push_back('{32'h305C, enc_j(6'h03, 32'h3100),       31, 32'h0000_3060, 3, 32'h3100});
    tbl.push_back('{32'h3100, enc_r(6'h08, 31, 0, 0, 0),    31, 32'h0000_3060, 3, 32'h3060});
    tbl.push_back('{32'h3060, enc_j(6'h02, 32'h3080),        0, 32'h0000_0000, 3, 32'h3080});
    tbl.push_back('{32'h3080, {6'h3F, 26'd0},               13, 32'h0000_0000, 3, 32'h3084});
    tbl.push_back('{32'h3084, enc_r(6'h25, 11, 12, 13, 0),  13, 32'h0000_8001, 4, 32'h3088});

    clear_im;
    foreach (tbl[i]) put(tbl[i].addr, tbl[i].ins);
    do_reset;
    foreach (tbl[i]) begin
      exec_one(cyc, wcnt, wa, wd);
      chk($sformatf("tbl%0d_cyc", i), 32'(cyc), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d_pc", i), dut.pc, tbl[i].npc);
      chk($sformatf("tbl%0d_r%0d", i, tbl[i].r), dut.gpr[tbl[i].r], tbl[i].rv);
      chk($sformatf("tbl%0d_wen", i), 32'(wcnt), 32'd0);
    end

    // ---------------- device bus store/load ----------------
    clear_im;
    put(32'h3000, enc_i(6'h0D, 0, 1, 16'h1234));
    put(32'h3004, enc_i(6'h2B, 0, 1, 16'h7F10));
    put(32'h3008, enc_i(6'h23, 0, 4, 16'h7F10));
    do_reset;
    PrDIn = 32'hCAFE_0001;
    exec_one(cyc, wcnt, wa, wd);
    exec_one(cyc, wcnt, wa, wd);
    chk("dev_sw_cyc", 32'(cyc), 32'd4);
    chk("dev_sw_wen_cnt", 32'(wcnt), 32'd1);
    chk("dev_sw_praddr", wa, 32'h0000_7F10);
    chk("dev_sw_prdout", wd, 32'h0000_1234);
    exec_one(cyc, wcnt, wa, wd);
    chk("dev_lw_cyc", 32'(cyc), 32'd5);
    chk("dev_lw_wen_cnt", 32'(wcnt), 32'd0);
    chk("dev_lw_r4", dut.gpr[4], 32'hCAFE_0001);

    // ---------------- interrupt entry and eret ----------------
    clear_im;
    put(32'h3000, enc_i(6'h0D, 0, 1, 16'h0401));
    put(32'h3004, enc_cop0(4, 1, 12));
    put(32'h3008, enc_cop0(0, 6, 14));
    put(32'h300C, enc_cop0(0, 7, 15));
    put(32'h4180, 32'h4200_0018);
    do_reset;
    HWInt = 6'b000001;
    exec_one(cyc, wcnt, wa, wd);
    exec_one(cyc, wcnt, wa, wd);
    chk("irq_mtc0_sr", dut.sr, 32'h0000_0401);
    exec_one(cyc, wcnt, wa, wd);
    chk("irq_entry_pc", dut.pc, 32'h0000_4180);
    chk("irq_epc", dut.epc, 32'h0000_3008);
    chk("irq_sr_exl", dut.sr, 32'h0000_0403);
    HWInt = '0;
    exec_one(cyc, wcnt, wa, wd);
    chk("eret_cyc", 32'(cyc), 32'd3);
    chk("eret_pc", dut.pc, 32'h0000_3008);
    chk("eret_sr", dut.sr, 32'h0000_0401);
    exec_one(cyc, wcnt, wa, wd);
    chk("mfc0_epc", dut.gpr[6], 32'h0000_3008);
    exec_one(cyc, wcnt, wa, wd);
    chk("mfc0_prid", dut.gpr[7], 32'h1234_5678);

    // ---------------- reset during lw memory cycle ----------------
    clear_im;
    put(32'h3000, enc_i(6'h23, 0, 3, 16'h7F10));
    do_reset;
    PrDIn = 32'hDEAD_BEEF;
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (dut.state != 3'd4 && cyc < 10);
    chk("abort_reached_s4", 32'(dut.state), 32'd4);
    rst = 1'b0;
    #1;
    chk("abort_pc", dut.pc, 32'h3000);
    chk("abort_state", 32'(dut.state), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("abort_r3", dut.gpr[3], 32'h0);
    rst = 1'b1;

    // ---------------- random programs against the ISA model ----------------
    for (int i = 0; i < 8; i++) put(32'h3000 + 32'(i * 4), enc_i(6'h2B, 0, 0, 16'(i * 4)));
    for (int i = 8; i < 1024; i++) put(32'h3000 + 32'(i * 4), rnd_instr());
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int i = 0; i < 1024; i++) mdm[i] = '0;
    m_pc = 32'h3000;
    do_reset;
    for (int n = 0; n < 400; n++) begin
      m_step(mcyc);
      exec_one(cyc, wcnt, wa, wd);
      chk($sformatf("rnd%0d_cyc", n), 32'(cyc), 32'(mcyc));
      chk($sformatf("rnd%0d_pc", n), dut.pc, m_pc);
      bad = -1;
      for (int r = 0; r < 32; r++)
        if (dut.gpr[r] !== mregs[r] && bad < 0) bad = r;
      j = (bad < 0) ? (n % 32) : bad;
      chk($sformatf("rnd%0d_r%0d", n, j), dut.gpr[j], mregs[j]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
